// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and enable/flush bundle layout for the pipeline controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } state_e;

   localparam int REG_ADDR_W_DEF = 5;

   // Bundle bit positions follow the pipeline register order PC, IF/ID, ID/EX, EX/MEM, MEM/WB
   localparam int CTRL_W       = 7;
   localparam int CTRL_PC_EN   = 0;
   localparam int CTRL_IFID_EN = 1;
   localparam int CTRL_IFID_FL = 2;
   localparam int CTRL_IDEX_EN = 3;
   localparam int CTRL_IDEX_FL = 4;
   localparam int CTRL_EXMEM_EN = 5;
   localparam int CTRL_MEMWB_EN = 6;

   localparam logic [CTRL_W-1:0] CTRL_EN_MASK  = 7'b1101011;
   localparam logic [CTRL_W-1:0] CTRL_RUN      = 7'b1101011;
   localparam logic [CTRL_W-1:0] CTRL_BRANCH   = 7'b1111111;
   localparam logic [CTRL_W-1:0] CTRL_LOAD_USE = 7'b1111000;
   localparam logic [CTRL_W-1:0] CTRL_DRAIN    = 7'b1101110;
   localparam logic [CTRL_W-1:0] CTRL_IDEX_FLM = 7'b0010000;
   localparam logic [CTRL_W-1:0] CTRL_RESET    = 7'b1111111;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones, with synchronous clear
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next value: hold once every bit is set
   always_comb cnt_d = (inc_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

   // count register, clear wins over increment
   always_ff @(posedge clk) cnt_q <= clr_i ? '0 : cnt_d;

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control, halt/drain/resume handshake and event counters
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  dmem_busy_i,
   input  logic                  halt_req_i,
   input  logic                  resume_req_i,
   output logic                  pc_en_o,
   output logic                  if_id_en_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_en_o,
   output logic                  id_ex_flush_o,
   output logic                  ex_mem_en_o,
   output logic                  mem_wb_en_o,
   output logic                  halted_o,
   output logic                  halt_ack_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_e            state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic              halt_ack_q, halt_ack_d;
   logic [CTRL_W-1:0] ctrl;
   logic              hazard, flush_ev, stall_ev, run_like;

   assign hazard   = ex_mem_read_i && ex_rd_i != '0 &&
                     (ex_rd_i == id_rs1_i || (id_uses_rs2_i && ex_rd_i == id_rs2_i));
   // MEM_WAIT with memory ready behaves exactly like RUN in the same cycle
   assign run_like = state_q == ST_RUN || state_q == ST_MEM_WAIT;

   // state, drain counter and ack pulse registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         drain_q    <= '0;
         halt_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         halt_ack_q <= halt_ack_d;
      end
   end

   // next-state selection
   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      halt_ack_d = 1'b0;
      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            state_d = dmem_busy_i ? ST_MEM_WAIT : ST_RUN;
            if (!dmem_busy_i && !ex_branch_taken_i && !hazard && halt_req_i) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (!dmem_busy_i && drain_q == '0) begin
               state_d    = ST_HALTED;
               halt_ack_d = 1'b1;
            end else if (!dmem_busy_i) begin
               drain_d = drain_q - DW'(1);
            end
         end
         ST_HALTED: state_d = resume_req_i ? ST_RUN : ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   // enable/flush bundle; reset forces every line high
   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_RUN, ST_MEM_WAIT:
            ctrl = dmem_busy_i       ? '0 :
                   ex_branch_taken_i ? CTRL_BRANCH :
                   hazard            ? CTRL_LOAD_USE :
                   halt_req_i        ? CTRL_DRAIN : CTRL_RUN;
         ST_DRAIN:
            ctrl = (dmem_busy_i ? (CTRL_DRAIN & ~CTRL_EN_MASK) : CTRL_DRAIN) |
                   (ex_branch_taken_i ? CTRL_IDEX_FLM : '0);
         default: ctrl = '0;
      endcase
      if (!rst_n) ctrl = CTRL_RESET;
   end

   assign flush_ev = run_like && !dmem_busy_i && ex_branch_taken_i;
   assign stall_ev = !ctrl[CTRL_PC_EN] && state_q != ST_HALTED;

   assign pc_en_o       = ctrl[CTRL_PC_EN];
   assign if_id_en_o    = ctrl[CTRL_IFID_EN];
   assign if_id_flush_o = ctrl[CTRL_IFID_FL];
   assign id_ex_en_o    = ctrl[CTRL_IDEX_EN];
   assign id_ex_flush_o = ctrl[CTRL_IDEX_FL];
   assign ex_mem_en_o   = ctrl[CTRL_EXMEM_EN];
   assign mem_wb_en_o   = ctrl[CTRL_MEMWB_EN];
   assign halted_o      = state_q == ST_HALTED;
   assign halt_ack_o    = halt_ack_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr_i (!rst_n),
      .inc_i (stall_ev),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr_i (!rst_n),
      .inc_i (flush_ev),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a behavioural model of the controller
module tb_pipe_hazard_ctrl;

   localparam int DC  = 4;
   localparam int SMX = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs2, ex_mem_read, ex_branch_taken, dmem_busy, halt_req, resume_req;

   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
   logic        halted, halt_ack;
   logic [31:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en, s_mem_wb_en;
   logic        s_halted, s_halt_ack;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
      .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_branch_taken_i(ex_branch_taken),
      .dmem_busy_i(dmem_busy), .halt_req_i(halt_req), .resume_req_i(resume_req),
      .pc_en_o(pc_en), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush), .id_ex_en_o(id_ex_en),
      .id_ex_flush_o(id_ex_flush), .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
      .halted_o(halted), .halt_ack_o(halt_ack), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   // narrow-counter copy so saturation is reachable within the run
   pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
      .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_branch_taken_i(ex_branch_taken),
      .dmem_busy_i(dmem_busy), .halt_req_i(halt_req), .resume_req_i(resume_req),
      .pc_en_o(s_pc_en), .if_id_en_o(s_if_id_en), .if_id_flush_o(s_if_id_flush), .id_ex_en_o(s_id_ex_en),
      .id_ex_flush_o(s_id_ex_flush), .ex_mem_en_o(s_ex_mem_en), .mem_wb_en_o(s_mem_wb_en),
      .halted_o(s_halted), .halt_ack_o(s_halt_ack), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   bit m_drain, m_halted, m_ack;
   int m_left, m_stalls, m_flushes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: check outputs mid-cycle against the model, then advance the model
   task automatic step();
      logic [6:0] e, o, os;
      logic       hz, b;
      @(negedge clk);
      b  = dmem_busy;
      hz = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
      if (!rst_n)               e = 7'b1111111;
      else if (m_halted)        e = 7'b0000000;
      else if (m_drain)         e = {~b, ~b, ex_branch_taken, ~b, 1'b1, ~b, 1'b0};
      else if (b)               e = 7'b0000000;
      else if (ex_branch_taken) e = 7'b1111111;
      else if (hz)              e = 7'b1111000;
      else if (halt_req)        e = 7'b1101110;
      else                      e = 7'b1101011;
      o  = {mem_wb_en, ex_mem_en, id_ex_flush, id_ex_en, if_id_flush, if_id_en, pc_en};
      os = {s_mem_wb_en, s_ex_mem_en, s_id_ex_flush, s_id_ex_en, s_if_id_flush, s_if_id_en, s_pc_en};
      chk("ctrl", 32'(o), 32'(e));
      chk("ctrl_s", 32'(os), 32'(e));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("halt_ack", 32'(halt_ack), 32'(m_ack));
      chk("halt_ack_s", 32'(s_halt_ack), 32'(m_ack));
      chk("stall_cnt", stall_cnt, 32'(m_stalls));
      chk("flush_cnt", flush_cnt, 32'(m_flushes));
      chk("stall_cnt_s", 32'(s_stall_cnt), 32'(m_stalls > SMX ? SMX : m_stalls));
      chk("flush_cnt_s", 32'(s_flush_cnt), 32'(m_flushes > SMX ? SMX : m_flushes));
      if (!rst_n) begin
         m_drain = 0; m_halted = 0; m_ack = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (!e[0] && !m_halted) m_stalls++;
         m_ack = 0;
         if (m_halted) begin
            if (resume_req) m_halted = 0;
         end else if (m_drain) begin
            if (!b) begin
               if (m_left == 0) begin m_drain = 0; m_halted = 1; m_ack = 1; end
               else m_left--;
            end
         end else if (!b) begin
            if (ex_branch_taken) m_flushes++;
            else if (!hz && halt_req) begin m_drain = 1; m_left = DC - 1; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs2 = 0; ex_mem_read = 0;
      ex_branch_taken = 0; dmem_busy = 0; halt_req = 0; resume_req = 0;
   endtask

   initial begin
      int ack_cyc;
      int base;
      rst_n = 0;
      idle();
      step(); step();
      rst_n = 1;
      step();
      chk("rst_stall", stall_cnt, 0);
      // load-use on rs1: one bubble, then the load has moved on
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
      step();
      idle(); step();
      chk("lu_stall", stall_cnt, 1);
      // x0 destination and unused rs2 never stall
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; step();
      ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_uses_rs2 = 0; step();
      idle(); step();
      chk("x0_stall", stall_cnt, 1);
      // branch beats a simultaneous load-use
      ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
      step();
      idle(); step();
      chk("br_flush", flush_cnt, 1);
      chk("br_stall", stall_cnt, 1);
      // three wait-state cycles
      base = stall_cnt;
      dmem_busy = 1; step(); step(); step();
      dmem_busy = 0; step();
      chk("busy_stall", stall_cnt, 32'(base + 3));
      chk("busy_resume_pc", 32'(pc_en), 1);
      // halt with one wait state during the drain
      ack_cyc = -1;
      halt_req = 1;
      for (int k = 0; k < 12; k++) begin
         dmem_busy = (k == 3);
         step();
         if (halt_ack && ack_cyc < 0) ack_cyc = k + 1;
      end
      chk("ack_cycle", 32'(ack_cyc), 32'(DC + 2));
      halt_req = 0; step(); step();
      chk("still_halted", 32'(halted), 1);
      resume_req = 1; step();
      resume_req = 0;
      chk("resume_pc", 32'(pc_en), 1);
      step();
      // reset in the middle of a drain
      halt_req = 1; step(); step();
      halt_req = 0; rst_n = 0; step();
      rst_n = 1;
      for (int k = 0; k < 8; k++) step();
      chk("rst_drain_ack", 32'(halt_ack), 0);
      chk("rst_drain_state", 32'(halted), 0);
      // random traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         rst_n           = ($urandom_range(299) != 0);
         id_rs1          = 5'($urandom_range(3));
         id_rs2          = 5'($urandom_range(3));
         ex_rd           = 5'($urandom_range(3));
         id_uses_rs2     = $urandom_range(1) == 1;
         ex_mem_read     = $urandom_range(1) == 1;
         ex_branch_taken = $urandom_range(5) == 0;
         dmem_busy       = $urandom_range(4) == 0;
         resume_req      = $urandom_range(7) == 0;
         if ($urandom_range(39) == 0) halt_req = ~halt_req;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
